// File: rtl/pulse_accumulator_pkg.sv
// Shared definitions for the pulse accumulator: state encoding used by the
// FSM and by any display or test code that needs to decode the state.
package pulse_accumulator_pkg;

  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_ADD      = 3'd2;
  localparam logic [2:0] ST_WAIT_REL = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  typedef enum logic [2:0] {
    INIT     = ST_INIT,
    IDLE     = ST_IDLE,
    ADD      = ST_ADD,
    WAIT_REL = ST_WAIT_REL,
    DONE     = ST_DONE
  } state_t;

endpackage

// File: rtl/pulse_accumulator_sat_adder.sv
// Combinational WIDTH-bit adder with carry out; optionally clamps the
// sum to all-ones when the addition overflows.
module sat_adder #(
  parameter int WIDTH = 8,
  parameter int SAT   = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};
  assign carry    = full_sum[WIDTH];

  generate
    if (SAT != 0) begin : g_sat
      assign sum = carry ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
    end else begin : g_wrap
      assign sum = full_sum[WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/pulse_accumulator.sv
// Press-driven accumulator: each debounced press of the active-low key adds
// `value` to the running total, up to MAX_ADDS accepted additions.
module pulse_accumulator
  import pulse_accumulator_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 4,
  parameter int MAX_ADDS = 10,
  parameter int SAT      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic [WIDTH-1:0] value,
  input  logic             clr,
  output logic [WIDTH-1:0] tot,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             done
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ADDS);

  state_t           state_q;
  logic [1:0]       sync_q;
  logic [WIDTH-1:0] tot_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             done_q;

  logic             x_s;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [CNT_W-1:0] count_d;

  assign x_s     = sync_q[1];
  assign count_d = count_q + CNT_W'(1);

  sat_adder #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_sat_adder (
    .a     (tot_q),
    .b     (value),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= INIT;
      tot_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], x};
      // Clear lands in WAIT_REL so a key still held down is not re-counted.
      if (clr) begin
        tot_q   <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
        done_q  <= 1'b0;
        state_q <= WAIT_REL;
      end else begin
        case (state_q)
          INIT: begin
            tot_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
          IDLE: begin
            if (!x_s) state_q <= ADD;
          end
          ADD: begin
            tot_q   <= sum;
            ovf_q   <= ovf_q | carry;
            count_q <= count_d;
            if (count_d == MAX_CNT) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT_REL;
            end
          end
          WAIT_REL: begin
            if (x_s) state_q <= IDLE;
          end
          DONE: begin
            state_q <= DONE;
          end
          default: state_q <= INIT;
        endcase
      end
    end
  end

  assign tot   = tot_q;
  assign count = count_q;
  assign ovf   = ovf_q;
  assign done  = done_q;

endmodule
